// File: rtl/ibex_fpu_wb_arbiter.sv
// Purpose : FP register-file writeback arbiter with a 32-entry busy scoreboard (WAW stall, RAW hazard check).
// Latency : 1 cycle from winning FPU/LSU result to rf_we_o; scoreboard set/clear take effect at the next edge.
// Backpres: LSU has fixed priority and is never stalled; FPU is held off via fpu_ready_o while LSU is valid.
//
// Ports:
//   clk_i, rst_ni                              clock, async active-low reset
//   issue_valid_i, issue_rd_i, issue_ready_o   issue of an FP-destination instruction (stalls on WAW)
//   chk_rs1_i, chk_rs2_i, hazard_o             source-register hazard lookup against the scoreboard
//   fpu_valid_i, fpu_rd_i, fpu_wdata_i,
//   fpu_ready_o                                FPU result, valid/ready handshake
//   lsu_valid_i, lsu_rd_i, lsu_wdata_i         FP load data, always accepted
//   rf_we_o, rf_waddr_o, rf_wdata_o            registered FP register-file write port
//   busy_o                                     scoreboard bitmap (bit n = write to f<n> outstanding)

module ibex_fpu_wb_arbiter #(
   parameter int unsigned DataWidth = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,

   input  logic                 issue_valid_i,
   input  logic [4:0]           issue_rd_i,
   output logic                 issue_ready_o,

   input  logic [4:0]           chk_rs1_i,
   input  logic [4:0]           chk_rs2_i,
   output logic                 hazard_o,

   input  logic                 fpu_valid_i,
   input  logic [4:0]           fpu_rd_i,
   input  logic [DataWidth-1:0] fpu_wdata_i,
   output logic                 fpu_ready_o,

   input  logic                 lsu_valid_i,
   input  logic [4:0]           lsu_rd_i,
   input  logic [DataWidth-1:0] lsu_wdata_i,

   output logic                 rf_we_o,
   output logic [4:0]           rf_waddr_o,
   output logic [DataWidth-1:0] rf_wdata_o,

   output logic [31:0]          busy_o
);

   logic [31:0]          r_busy;
   logic                 r_we;
   logic [4:0]           r_waddr;
   logic [DataWidth-1:0] r_wdata;

   logic                 w_set_en;
   logic                 w_fpu_win;
   logic                 w_win;
   logic [4:0]           w_win_rd;
   logic [DataWidth-1:0] w_win_wdata;
   logic [31:0]          w_set_mask;
   logic [31:0]          w_clr_mask;
   logic [31:0]          w_busy_nxt;

   // ---------------------------------------------------------------
   // Combinational handshakes and hazard lookup
   // ---------------------------------------------------------------
   assign issue_ready_o = ~r_busy[issue_rd_i];
   assign hazard_o      = r_busy[chk_rs1_i] | r_busy[chk_rs2_i];
   assign fpu_ready_o   = ~lsu_valid_i;

   assign w_set_en  = issue_valid_i & issue_ready_o;
   assign w_fpu_win = fpu_valid_i & fpu_ready_o;
   assign w_win     = lsu_valid_i | w_fpu_win;

   // LSU overrides FPU; when neither wins the mux output is unused.
   always_comb begin
      w_win_rd    = fpu_rd_i;
      w_win_wdata = fpu_wdata_i;
      if (lsu_valid_i) begin
         w_win_rd    = lsu_rd_i;
         w_win_wdata = lsu_wdata_i;
      end
   end

   // ---------------------------------------------------------------
   // Scoreboard next state. The clear comes from the registered write
   // port, so the bit drops on the same edge the register file samples
   // the data. Set is applied after clear so it wins on a collision.
   // ---------------------------------------------------------------
   always_comb begin
      w_set_mask = '0;
      w_clr_mask = '0;
      if (w_set_en) begin
         w_set_mask[issue_rd_i] = 1'b1;
      end
      if (r_we) begin
         w_clr_mask[r_waddr] = 1'b1;
      end
      w_busy_nxt = (r_busy & ~w_clr_mask) | w_set_mask;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_nxt;
      end
   end

   // ---------------------------------------------------------------
   // Writeback register. Address/data hold when there is no winner so
   // the write port only toggles on real writes.
   // ---------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else begin
         r_we <= w_win;
         if (w_win) begin
            r_waddr <= w_win_rd;
            r_wdata <= w_win_wdata;
         end
      end
   end

   assign rf_we_o    = r_we;
   assign rf_waddr_o = r_waddr;
   assign rf_wdata_o = r_wdata;
   assign busy_o     = r_busy;

   // ---------------------------------------------------------------
   // Simulation checks for conditions the pipeline should never create.
   // ---------------------------------------------------------------
   // Issue stalls on a busy rd, so set+clear of one register means a
   // writeback arrived for a register that was not outstanding.
   a_set_clr_same_rd : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(w_set_en && r_we && (issue_rd_i == r_waddr)));

   // Every writeback should retire an outstanding write.
   a_wb_not_busy : assert property (@(posedge clk_i) disable iff (!rst_ni)
      r_we |-> r_busy[r_waddr]);

endmodule

// File: tb/tb_ibex_fpu_wb_arbiter.sv
module tb_ibex_fpu_wb_arbiter;

   localparam int DW = 32;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          issue_valid_i;
   logic [4:0]    issue_rd_i;
   logic          issue_ready_o;
   logic [4:0]    chk_rs1_i;
   logic [4:0]    chk_rs2_i;
   logic          hazard_o;
   logic          fpu_valid_i;
   logic [4:0]    fpu_rd_i;
   logic [DW-1:0] fpu_wdata_i;
   logic          fpu_ready_o;
   logic          lsu_valid_i;
   logic [4:0]    lsu_rd_i;
   logic [DW-1:0] lsu_wdata_i;
   logic          rf_we_o;
   logic [4:0]    rf_waddr_o;
   logic [DW-1:0] rf_wdata_o;
   logic [31:0]   busy_o;

   always #5 clk_i = ~clk_i;

   ibex_fpu_wb_arbiter #(.DataWidth(DW)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .issue_valid_i (issue_valid_i),
      .issue_rd_i    (issue_rd_i),
      .issue_ready_o (issue_ready_o),
      .chk_rs1_i     (chk_rs1_i),
      .chk_rs2_i     (chk_rs2_i),
      .hazard_o      (hazard_o),
      .fpu_valid_i   (fpu_valid_i),
      .fpu_rd_i      (fpu_rd_i),
      .fpu_wdata_i   (fpu_wdata_i),
      .fpu_ready_o   (fpu_ready_o),
      .lsu_valid_i   (lsu_valid_i),
      .lsu_rd_i      (lsu_rd_i),
      .lsu_wdata_i   (lsu_wdata_i),
      .rf_we_o       (rf_we_o),
      .rf_waddr_o    (rf_waddr_o),
      .rf_wdata_o    (rf_wdata_o),
      .busy_o        (busy_o)
   );

   int n_vec = 0;
   int n_err = 0;
   bit cmp_on = 1'b0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, got, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------
   // Reference model: set of outstanding registers plus the write
   // that the register file will see in the next cycle.
   // ---------------------------------------------------------------
   logic [31:0]   m_busy;
   logic          m_we;
   logic [4:0]    m_waddr;
   logic [DW-1:0] m_wdata;

   function automatic logic [31:0] next_busy(input logic [31:0] b, input logic we,
                                             input logic [4:0] wa, input logic iv,
                                             input logic [4:0] ir);
      logic [31:0] r;
      r = b;
      if (we) r[wa] = 1'b0;
      if (iv && !b[ir]) r[ir] = 1'b1;
      return r;
   endfunction

   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         m_busy  <= '0;
         m_we    <= 1'b0;
         m_waddr <= '0;
         m_wdata <= '0;
      end else begin
         m_busy <= next_busy(m_busy, m_we, m_waddr, issue_valid_i, issue_rd_i);
         if (lsu_valid_i) begin
            m_we    <= 1'b1;
            m_waddr <= lsu_rd_i;
            m_wdata <= lsu_wdata_i;
         end else if (fpu_valid_i) begin
            m_we    <= 1'b1;
            m_waddr <= fpu_rd_i;
            m_wdata <= fpu_wdata_i;
         end else begin
            m_we <= 1'b0;
         end
      end
   end

   // Per-cycle comparison, mid-cycle, away from the active edge.
   always @(negedge clk_i) begin
      if (cmp_on) begin
         chk("issue_ready", issue_ready_o, !m_busy[issue_rd_i]);
         chk("hazard", hazard_o, m_busy[chk_rs1_i] | m_busy[chk_rs2_i]);
         chk("fpu_ready", fpu_ready_o, !lsu_valid_i);
         chk("busy", busy_o, m_busy);
         chk("rf_we", rf_we_o, m_we);
         chk("rf_waddr", rf_waddr_o, m_waddr);
         chk("rf_wdata", rf_wdata_o, m_wdata);
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      issue_valid_i = 1'b0;
      issue_rd_i    = '0;
      chk_rs1_i     = '0;
      chk_rs2_i     = '0;
      fpu_valid_i   = 1'b0;
      fpu_rd_i      = '0;
      fpu_wdata_i   = '0;
      lsu_valid_i   = 1'b0;
      lsu_rd_i      = '0;
      lsu_wdata_i   = '0;
   endtask

   int pool[$];

   initial begin
      rst_ni = 1'b0;
      idle();
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_busy", busy_o, 32'h0);
      chk("rst_we", rf_we_o, 1'b0);
      chk("rst_waddr", rf_waddr_o, 5'd0);
      chk("rst_wdata", rf_wdata_o, 32'h0);
      chk("rst_issue_ready", issue_ready_o, 1'b1);
      chk("rst_hazard", hazard_o, 1'b0);
      chk("rst_fpu_ready", fpu_ready_o, 1'b1);
      cmp_on = 1'b1;
      rst_ni = 1'b1;

      // Issue f5, FPU result three cycles later
      issue_valid_i = 1'b1; issue_rd_i = 5'd5;
      #1 chk("d1_issue_ready", issue_ready_o, 1'b1);
      tick();
      issue_valid_i = 1'b0;
      chk("d1_busy_set", busy_o, 32'h0000_0020);
      tick(); tick();
      fpu_valid_i = 1'b1; fpu_rd_i = 5'd5; fpu_wdata_i = 32'h3F80_0000;
      #1 chk("d1_fpu_ready", fpu_ready_o, 1'b1);
      tick();
      fpu_valid_i = 1'b0;
      chk("d1_we", rf_we_o, 1'b1);
      chk("d1_waddr", rf_waddr_o, 5'd5);
      chk("d1_wdata", rf_wdata_o, 32'h3F80_0000);
      chk("d1_busy_held", busy_o, 32'h0000_0020);
      tick();
      chk("d1_busy_clr", busy_o, 32'h0);
      chk("d1_we_off", rf_we_o, 1'b0);
      chk("d1_waddr_hold", rf_waddr_o, 5'd5);

      // Hazard lookup
      issue_valid_i = 1'b1; issue_rd_i = 5'd3;
      tick();
      issue_valid_i = 1'b0;
      chk_rs1_i = 5'd3; chk_rs2_i = 5'd0;
      #1 chk("d2_hazard_rs1", hazard_o, 1'b1);
      chk_rs1_i = 5'd0; chk_rs2_i = 5'd4;
      #1 chk("d2_hazard_none", hazard_o, 1'b0);
      lsu_valid_i = 1'b1; lsu_rd_i = 5'd3; lsu_wdata_i = 32'h0000_0333;
      tick();
      lsu_valid_i = 1'b0;
      tick();
      chk("d2_busy_clr", busy_o, 32'h0);

      // LSU and FPU collide: LSU first, FPU next cycle
      issue_valid_i = 1'b1; issue_rd_i = 5'd2;
      tick();
      issue_rd_i = 5'd7;
      tick();
      issue_valid_i = 1'b0;
      lsu_valid_i = 1'b1; lsu_rd_i = 5'd2; lsu_wdata_i = 32'hAAAA_0002;
      fpu_valid_i = 1'b1; fpu_rd_i = 5'd7; fpu_wdata_i = 32'h5555_0007;
      #1 chk("d3_fpu_stalled", fpu_ready_o, 1'b0);
      tick();
      lsu_valid_i = 1'b0;
      chk("d3_lsu_we", rf_we_o, 1'b1);
      chk("d3_lsu_waddr", rf_waddr_o, 5'd2);
      chk("d3_lsu_wdata", rf_wdata_o, 32'hAAAA_0002);
      #1 chk("d3_fpu_ready", fpu_ready_o, 1'b1);
      tick();
      fpu_valid_i = 1'b0;
      chk("d3_fpu_we", rf_we_o, 1'b1);
      chk("d3_fpu_waddr", rf_waddr_o, 5'd7);
      chk("d3_fpu_wdata", rf_wdata_o, 32'h5555_0007);
      chk("d3_busy", busy_o, 32'h0000_0080);
      tick();
      chk("d3_busy_clr", busy_o, 32'h0);

      // WAW stall until the clearing edge
      issue_valid_i = 1'b1; issue_rd_i = 5'd9;
      tick();
      #1 chk("d4_stall", issue_ready_o, 1'b0);
      lsu_valid_i = 1'b1; lsu_rd_i = 5'd9; lsu_wdata_i = 32'h0000_0999;
      tick();
      lsu_valid_i = 1'b0;
      chk("d4_we", rf_we_o, 1'b1);
      chk("d4_stall_wb", issue_ready_o, 1'b0);
      tick();
      chk("d4_ready", issue_ready_o, 1'b1);
      chk("d4_busy", busy_o, 32'h0);
      issue_valid_i = 1'b0;

      // Simultaneous set f1 / clear f4
      issue_valid_i = 1'b1; issue_rd_i = 5'd4;
      tick();
      issue_valid_i = 1'b0;
      lsu_valid_i = 1'b1; lsu_rd_i = 5'd4; lsu_wdata_i = 32'h0000_0444;
      tick();
      lsu_valid_i = 1'b0;
      chk("d5_we", rf_we_o, 1'b1);
      issue_valid_i = 1'b1; issue_rd_i = 5'd1;
      tick();
      issue_valid_i = 1'b0;
      chk("d5_busy", busy_o, 32'h0000_0002);
      lsu_valid_i = 1'b1; lsu_rd_i = 5'd1; lsu_wdata_i = 32'h0000_0111;
      tick();
      lsu_valid_i = 1'b0;
      tick();
      chk("d5_busy_clr", busy_o, 32'h0);

      // Full scoreboard + pending write, then reset
      for (int i = 0; i < 32; i++) begin
         issue_valid_i = 1'b1; issue_rd_i = 5'(i);
         tick();
      end
      issue_valid_i = 1'b0;
      lsu_valid_i = 1'b1; lsu_rd_i = 5'd0; lsu_wdata_i = 32'hDEAD_BEEF;
      tick();
      lsu_valid_i = 1'b0;
      chk("d6_busy_full", busy_o, 32'hFFFF_FFFF);
      chk("d6_we", rf_we_o, 1'b1);
      rst_ni = 1'b0;
      #1;
      chk("d6_rst_busy", busy_o, 32'h0);
      chk("d6_rst_we", rf_we_o, 1'b0);
      chk("d6_rst_waddr", rf_waddr_o, 5'd0);
      chk("d6_rst_wdata", rf_wdata_o, 32'h0);
      chk("d6_rst_ready", issue_ready_o, 1'b1);
      lsu_valid_i = 1'b1;
      #1 chk("d6_rst_fpu_rdy_lo", fpu_ready_o, 1'b0);
      lsu_valid_i = 1'b0;
      #1 chk("d6_rst_fpu_rdy_hi", fpu_ready_o, 1'b1);
      tick();
      rst_ni = 1'b1;
      #1 chk("d6_no_wb_after_rel", rf_we_o, 1'b0);
      tick();
      chk("d6_no_wb_edge", rf_we_o, 1'b0);

      // Randomized traffic; writebacks only target outstanding registers
      pool.delete();
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if ($urandom_range(0, 599) == 0) begin
            rst_ni = 1'b0;
            idle();
            pool.delete();
            tick();
            rst_ni = 1'b1;
         end else begin
            // FPU result accepted at the edge just taken
            if (fpu_valid_i && !lsu_valid_i) fpu_valid_i = 1'b0;

            lsu_wdata_i = $urandom;
            lsu_rd_i    = 5'($urandom_range(0, 31));
            lsu_valid_i = 1'b0;
            if (pool.size() > 0 && $urandom_range(0, 2) == 0) begin
               int k;
               k = $urandom_range(0, pool.size() - 1);
               lsu_rd_i = 5'(pool[k]);
               pool.delete(k);
               lsu_valid_i = 1'b1;
            end

            if (!fpu_valid_i) begin
               fpu_rd_i    = 5'($urandom_range(0, 31));
               fpu_wdata_i = $urandom;
               if (pool.size() > 0 && $urandom_range(0, 1) == 1) begin
                  int k;
                  k = $urandom_range(0, pool.size() - 1);
                  fpu_rd_i = 5'(pool[k]);
                  pool.delete(k);
                  fpu_valid_i = 1'b1;
               end
            end

            issue_valid_i = 1'($urandom_range(0, 1));
            issue_rd_i    = 5'($urandom_range(0, 31));
            if (issue_valid_i && !m_busy[issue_rd_i]) pool.push_back(int'(issue_rd_i));

            chk_rs1_i = 5'($urandom_range(0, 31));
            chk_rs2_i = 5'($urandom_range(0, 31));
         end
         tick();
      end

      idle();
      repeat (3) tick();
      cmp_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ibex_fpu_wb_arbiter.md
IBEX_FPU_WB_ARBITER -- requirements
Module: ibex_fpu_wb_arbiter

Interface
REQ-001 The block SHALL have parameter DataWidth, default 32, meaning FP register width.
REQ-002 The block SHALL have port clk_i, input, 1, meaning the single clock; all state is on its rising edge.
REQ-003 The block SHALL have port rst_ni, input, 1, meaning asynchronous active-low reset.
REQ-004 The block SHALL have port issue_valid_i, input, 1, meaning an FP-destination instruction requests issue.
REQ-005 The block SHALL have port issue_rd_i, input, 5, meaning the destination register of the issuing instruction.
REQ-006 The block SHALL have port issue_ready_o, output, 1, meaning issue is accepted this cycle.
REQ-007 The block SHALL have ports chk_rs1_i and chk_rs2_i, input, 5 each, meaning source registers to hazard-check.
REQ-008 The block SHALL have port hazard_o, output, 1, meaning a checked source is pending write.
REQ-009 The block SHALL have ports fpu_valid_i (1), fpu_rd_i (5) and fpu_wdata_i (DataWidth), all inputs, meaning an FPU result.
REQ-010 The block SHALL have port fpu_ready_o, output, 1, meaning the FPU result is accepted this cycle.
REQ-011 The block SHALL have ports lsu_valid_i (1), lsu_rd_i (5) and lsu_wdata_i (DataWidth), all inputs, meaning FP load data; no backpressure.
REQ-012 The block SHALL have ports rf_we_o (1), rf_waddr_o (5) and rf_wdata_o (DataWidth), all outputs, driving the FP register file write port.
REQ-013 The block SHALL have port busy_o, output, 32, meaning the scoreboard bitmap.

Function
REQ-014 Scoreboard: a 32-bit busy register; bit n set means a write to f<n> is outstanding.
REQ-015 issue_ready_o SHALL equal NOT busy[issue_rd_i] (WAW stall), combinationally.
REQ-016 On an edge with issue_valid_i AND issue_ready_o, busy[issue_rd_i] SHALL be set.
REQ-017 hazard_o SHALL equal busy[chk_rs1_i] OR busy[chk_rs2_i], combinationally; all 32 registers are real (no hardwired zero).
REQ-018 Arbitration: lsu_valid_i has fixed priority; fpu_ready_o SHALL equal NOT lsu_valid_i.
REQ-019 Winner selection: the LSU wins when lsu_valid_i=1; the FPU wins when fpu_valid_i AND fpu_ready_o; otherwise there is no winner.
REQ-020 The winner's rd and data SHALL be registered into rf_waddr_o and rf_wdata_o, with rf_we_o=1 on the next cycle; latency is exactly 1 cycle.
REQ-021 With no winner, rf_we_o SHALL be 0 next cycle, and rf_waddr_o and rf_wdata_o SHALL hold their previous values.
REQ-022 Clear rule: busy[rf_waddr_o] SHALL be cleared on the rising edge at which rf_we_o=1, which is the same edge the register file samples the data.
REQ-023 Simultaneous set of rd X and clear of rd Y at one edge, X≠Y: both SHALL take effect.
REQ-024 Set and clear of the same rd at one edge is unreachable by REQ-015; it SHALL be flagged by a simulation assertion, with set winning.
REQ-025 A writeback to a register whose busy bit is 0 SHALL still write and leave the bit 0; it SHALL be flagged by a simulation assertion.
REQ-026 busy_o SHALL be the registered bitmap itself.
REQ-027 The FPU handshake SHALL be valid/ready: fpu_valid_i, fpu_rd_i and fpu_wdata_i are held stable by the source until accepted; the block SHALL NOT require ready before valid.

Reset
REQ-028 While rst_ni=0, asynchronously: busy=0, rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0.
REQ-029 Reset mid-operation SHALL discard any pending writeback and all scoreboard state; no write SHALL be issued in the first cycle after release.
REQ-030 With busy=0 after reset: issue_ready_o=1 and hazard_o=0; fpu_ready_o follows lsu_valid_i.

Verification
REQ-031 Issue rd=5, then 3 cycles later FPU rd=5 with data 0x3F800000 -> rf_we_o=1, rf_waddr_o=5 and rf_wdata_o=0x3F800000 one cycle later; busy[5] clears at that edge.
REQ-032 In the same cycle, lsu_valid rd=2 and fpu_valid rd=7 -> LSU written first and fpu_ready_o=0; FPU rd=7 written the following cycle while fpu_valid is held.
REQ-033 busy[9]=1 with issue rd=9 -> issue_ready_o=0 until the edge where the rd=9 write clears the bit, then 1.
REQ-034 busy[3]=1 with chk_rs1_i=3 -> hazard_o=1; chk_rs2_i=4 alone with busy[4]=0 -> hazard_o=0.
REQ-035 At one edge, issue rd=1 and writeback of rd=4 clearing busy[4] -> busy_o=0x00000002 afterwards.
REQ-036 Assert rst_ni with busy=0xFFFFFFFF and rf_we_o=1 -> outputs and busy zero immediately; no write in the first cycle after release.
